// File: rtl/psum_accumulator.sv
// psum_accumulator: groups signed 25-bit partial sums from the PE into
// acc_len-term sums, then requantises each sum to a signed 8-bit result
// (arithmetic right shift followed by saturation). The result is held in a
// single output register with a valid/ready handshake and a sticky overrun flag.
// Optional build macro: PSUM_ACCUMULATOR_RELU_EN. When it is defined, negative
// sums are clamped to zero before the shift.
module psum_accumulator #(
  parameter int CNT_W = 8,
  parameter int ACC_W = 33
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [24:0]      psum_in,
  input  logic                    psum_valid,
  input  logic        [CNT_W-1:0] acc_len,
  input  logic        [4:0]       shift,
  output logic signed [7:0]       out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    ovr
);

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-7){1'b0}}, 7'h7f};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-7){1'b1}}, 7'h00};

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic        [CNT_W-1:0]  cnt_q, cnt_d;
  logic        [CNT_W-1:0]  len_q, len_d;
  logic        [4:0]        shift_q, shift_d;
  logic signed [7:0]        out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic                     ovr_q, ovr_d;

  logic signed [ACC_W-1:0]  psum_ext;
  logic        [CNT_W-1:0]  first_len;
  logic                     complete;
  logic signed [ACC_W-1:0]  final_sum;
  logic        [4:0]        final_shift;
  logic signed [ACC_W-1:0]  relu_sum;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [7:0]        sat_val;

  // Group completion detection and requantisation of the finishing sum
  always_comb begin
    psum_ext  = {{(ACC_W-25){psum_in[24]}}, psum_in};
    // A zero length is treated as a one-term group
    first_len = (acc_len == '0) ? CNT_W'(1) : acc_len;

    complete = 1'b0;
    if (psum_valid) begin
      if (state_q == IDLE) begin
        complete = (first_len == CNT_W'(1));
      end else begin
        complete = (cnt_q == (len_q - CNT_W'(1)));
      end
    end

    // A one-term group finishes in IDLE, so it uses the live shift input
    if (state_q == IDLE) begin
      final_sum   = psum_ext;
      final_shift = shift;
    end else begin
      final_sum   = acc_q + psum_ext;
      final_shift = shift_q;
    end

`ifdef PSUM_ACCUMULATOR_RELU_EN
    relu_sum = final_sum[ACC_W-1] ? '0 : final_sum;
`else
    relu_sum = final_sum;
`endif

    shifted = relu_sum >>> final_shift;

    if (shifted > SAT_MAX) begin
      sat_val = 8'sh7f;
    end else if (shifted < SAT_MIN) begin
      sat_val = -8'sd128;
    end else begin
      sat_val = shifted[7:0];
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: open a group on the first psum unless it is a one-term group
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (psum_valid && !complete) state_d = ACCUM;
      ACCUM:   if (complete) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q == ACCUM);
  end

  // Accumulator, term counter and per-group parameter latching
  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    shift_d = shift_q;
    if (psum_valid) begin
      if (state_q == IDLE) begin
        // Group parameters are frozen here; later input changes are ignored
        acc_d   = psum_ext;
        cnt_d   = CNT_W'(1);
        len_d   = first_len;
        shift_d = shift;
      end else begin
        acc_d = final_sum;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Output register: load on completion unless a held result is still unconsumed
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    ovr_d       = ovr_q;
    if (complete) begin
      if (out_valid_q && !out_ready) begin
        ovr_d = 1'b1;
      end else begin
        out_data_d  = sat_val;
        out_valid_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      shift_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      shift_q     <= shift_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      ovr_q       <= ovr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign ovr       = ovr_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Testbench for psum_accumulator: directed scenarios plus randomized traffic,
// compared cycle by cycle against an arithmetic group-sum reference model.
module tb_psum_accumulator;

  localparam int CNT_W = 8;
  localparam int ACC_W = 33;

  logic                    clk;
  logic                    rst_n;
  logic signed [24:0]      psum_in;
  logic                    psum_valid;
  logic        [CNT_W-1:0] acc_len;
  logic        [4:0]       shift;
  logic signed [7:0]       out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    busy;
  logic                    ovr;

  psum_accumulator #(.CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .psum_in   (psum_in),
    .psum_valid(psum_valid),
    .acc_len   (acc_len),
    .shift     (shift),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .ovr       (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: an open group is a running sum and a count of terms still owed
  bit     m_open;
  int     m_left;
  longint m_sum;
  int     m_sh;
  bit     m_ov;
  int     m_od;
  bit     m_ovr;
  int     m_done;
  bit     m_complete;

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int requant(input longint s, input int sh);
    longint v;
    v = s;
`ifdef PSUM_ACCUMULATOR_RELU_EN
    if (v < 0) v = 0;
`endif
    v = v >>> sh;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return int'(v);
  endfunction

  task automatic model_reset();
    m_open = 0; m_left = 0; m_sum = 0; m_sh = 0;
    m_ov = 0; m_od = 0; m_ovr = 0; m_complete = 0;
  endtask

  task automatic model_step(input bit pv, input int pin, input int len, input int sh, input bit rdy);
    int res;
    m_complete = 0;
    if (pv) begin
      if (!m_open) begin
        m_sum  = pin;
        m_sh   = sh;
        m_left = ((len == 0) ? 1 : len) - 1;
        if (m_left == 0) m_complete = 1;
        else m_open = 1;
      end else begin
        m_sum  = m_sum + pin;
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_complete = 1;
          m_open = 0;
        end
      end
    end
    if (m_complete) begin
      res = requant(m_sum, m_sh);
      m_done++;
      if (m_ov && !rdy) begin
        m_ovr = 1;
        $display("txn %0d: sum=%0d shift=%0d result=%0d dropped (overrun)", m_done, m_sum, m_sh, res);
      end else begin
        m_od = res;
        m_ov = 1;
        $display("txn %0d: sum=%0d shift=%0d result=%0d", m_done, m_sum, m_sh, res);
      end
    end else if (m_ov && rdy) begin
      m_ov = 0;
    end
  endtask

  // One clock: drive inputs, advance model, then compare just after the edge
  task automatic cycle(input bit pv, input int pin, input int len, input int sh, input bit rdy);
    psum_valid = pv;
    psum_in    = 25'(pin);
    acc_len    = CNT_W'(len);
    shift      = 5'(sh);
    out_ready  = rdy;
    model_step(pv, pin, len, sh, rdy);
    @(posedge clk);
    #1;
    check("out_valid", longint'(out_valid), longint'(m_ov));
    check("out_data", longint'(out_data), longint'(m_od));
    check("busy", longint'(busy), longint'(m_open));
    check("ovr", longint'(ovr), longint'(m_ovr));
  endtask

  // Asynchronous reset: outputs must clear before any clock edge arrives
  task automatic do_reset();
    psum_valid = 0;
    rst_n = 0;
    #1;
    check("rst_out_data", longint'(out_data), 0);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_ovr", longint'(ovr), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  int exp_v;
  int n_out;

  initial begin
    rst_n = 1; psum_valid = 0; psum_in = '0; acc_len = '0; shift = '0; out_ready = 1;
    m_done = 0;
    @(posedge clk);
    #1;
    do_reset();

    // Four-term group, no shift
    cycle(1, 10, 4, 0, 1);
    cycle(1, 20, 9, 3, 1);   // changed len/shift mid-group must be ignored
    cycle(1, 30, 4, 0, 1);
    cycle(1, 40, 4, 0, 1);
    check("sum4_data", longint'(out_data), 100);
    check("sum4_valid", longint'(out_valid), 1);
    cycle(0, 0, 4, 0, 1);

    // Saturation both directions
    cycle(1, 1000, 2, 2, 1);
    cycle(1, 1000, 2, 2, 1);
    check("sat_hi", longint'(out_data), 127);
    cycle(1, -1000, 2, 2, 1);
    cycle(1, -1000, 2, 2, 1);
`ifdef PSUM_ACCUMULATOR_RELU_EN
    exp_v = 0;
`else
    exp_v = -128;
`endif
    check("sat_lo", longint'(out_data), longint'(exp_v));

    // Negative sum and floor shift
    cycle(1, -50, 2, 0, 1);
    cycle(1, -10, 2, 0, 1);
`ifdef PSUM_ACCUMULATOR_RELU_EN
    exp_v = 0;
`else
    exp_v = -60;
`endif
    check("neg_sum", longint'(out_data), longint'(exp_v));
    cycle(1, -3, 2, 1, 1);
    cycle(1, 0, 2, 1, 1);
`ifdef PSUM_ACCUMULATOR_RELU_EN
    exp_v = 0;
`else
    exp_v = -2;
`endif
    check("floor_shift", longint'(out_data), longint'(exp_v));
    cycle(0, 0, 2, 0, 1);

    // Overrun, then simultaneous consume and complete
    cycle(1, 5, 1, 0, 0);
    cycle(1, 7, 1, 0, 0);
    check("ovr_keep_data", longint'(out_data), 5);
    check("ovr_flag", longint'(ovr), 1);
    cycle(1, 9, 1, 0, 1);
    check("swap_data", longint'(out_data), 9);
    check("swap_valid", longint'(out_valid), 1);
    cycle(0, 0, 1, 0, 1);

    // Reset mid-group discards the partial sum
    cycle(1, 1, 4, 0, 1);
    cycle(1, 1, 4, 0, 1);
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, 2, 4, 0, 1);
    check("post_rst_sum", longint'(out_data), 8);

    // Zero length behaves as one; back-to-back groups without bubbles
    for (int i = 0; i < 3; i++) begin
      cycle(1, i + 1, 0, 0, 1);
      check("len0_valid", longint'(out_valid), 1);
    end
    n_out = 0;
    for (int i = 0; i < 9; i++) begin
      cycle(1, i, 3, 0, 1);
      if (m_complete) n_out++;
      if (out_valid) check("len3_data", longint'(out_data), longint'(3 * i - 3));
    end
    check("len3_count", longint'(n_out), 3);
    check("len3_ovr", longint'(ovr), 0);
    cycle(0, 0, 3, 0, 1);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      int pin;
      if ($urandom_range(0, 3) == 0) pin = $urandom_range(0, 33554431) - 16777216;
      else pin = $urandom_range(0, 4000) - 2000;
      if (i % 500 == 499) do_reset();
      cycle($urandom_range(0, 3) != 0, pin, $urandom_range(0, 5),
            $urandom_range(0, 14), $urandom_range(0, 4) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/psum_accumulator.md
PSUM_ACCUMULATOR -- requirements
Module: psum_accumulator

Interface
REQ-001 Parameter CNT_W, default 8: width of acc_len and the internal term counter.
REQ-002 Parameter ACC_W, default 33: accumulator width; SHALL be at least 25+CNT_W so accumulation never wraps.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 psum_in  input  25  signed partial sum from the upstream 4-lane PE.
REQ-006 psum_valid  input  1  psum_in is valid this cycle; no backpressure toward the PE.
REQ-007 acc_len  input  CNT_W  number of psums per output, sampled on the first psum of each group.
REQ-008 shift  input  5  requantisation right-shift, sampled with acc_len.
REQ-009 out_data  output  8  signed requantised result.
REQ-010 out_valid  output  1  out_data holds an unconsumed result.
REQ-011 out_ready  input  1  consumer accepts out_data when out_valid && out_ready.
REQ-012 busy  output  1  high while a group is partially accumulated.
REQ-013 ovr  output  1  sticky overrun flag.

Function
REQ-014 FSM: IDLE (no group open) and ACCUM (group open); busy SHALL equal (state == ACCUM).
REQ-015 IDLE, psum_valid: latch len = max(acc_len,1) and shift; acc <= sign-extended psum_in; cnt <= 1; go ACCUM, unless len == 1, in which case complete immediately (REQ-017) and stay IDLE.
REQ-016 ACCUM, psum_valid: acc <= acc + sext(psum_in); cnt <= cnt + 1; cycles without psum_valid hold all state.
REQ-017 Completion on the edge accepting the len-th psum: final = acc + sext(psum_in); out_data <= sat8(final >>> shift); go IDLE; out_valid rises that same edge (1-cycle latency from last psum_valid).
REQ-018 >>> is arithmetic (floor toward minus infinity); sat8 clamps to [-128, 127].
REQ-019 out_valid clears on an edge with out_valid && out_ready and no completion on that edge.
REQ-020 Completion while out_valid && !out_ready: new result dropped, out_data/out_valid unchanged, ovr <= 1; ovr cleared only by reset.
REQ-021 Completion on the same edge as out_valid && out_ready: new result loaded, out_valid stays 1, no overrun.
REQ-022 psum_valid every cycle SHALL be sustained with no bubble between groups (the cycle after a completion may start the next group).
REQ-023 acc_len/shift changes during ACCUM have no effect on the open group.

Reset
REQ-024 rst_n low: state IDLE, acc, cnt, len, shift registers = 0; out_data = 0, out_valid = 0, busy = 0, ovr = 0, regardless of clk.
REQ-025 Reset mid-group discards the partial sum; the first psum_valid after release starts a new group.

Configuration
REQ-026 Macro PSUM_ACCUMULATOR_RELU_EN: when defined, final values below zero are forced to 0 before shift/saturation (out_data range [0,127]); when undefined, signed output per REQ-017/018 with no clamping at zero.

Verification
REQ-027 acc_len=4, shift=0, psums 10,20,30,40 on consecutive cycles -> out_valid=1 and out_data=100 the cycle after the 40; busy high for exactly 3 cycles.
REQ-028 acc_len=2, shift=2, psums 1000,1000 -> out_data=127 (2000>>>2=500 saturated); psums -1000,-1000 -> -128 (no RELU).
REQ-029 acc_len=2, shift=0, psums -50,-10 -> out_data=-60 without PSUM_ACCUMULATOR_RELU_EN, 0 with it; shift=1, psums -3,0, no RELU -> out_data=-2 (floor).
REQ-030 acc_len=1, out_ready=0, psums 5 then 7 back-to-back -> out_data stays 5, ovr=1; then out_ready=1 with simultaneous completion of psum 9 -> out_data=9, out_valid stays 1.
REQ-031 acc_len=4, after 2 psums (1,1) assert rst_n low one cycle -> all outputs 0; then psums 2,2,2,2 -> out_data=8.
REQ-032 acc_len=0 -> each psum produces one output (treated as 1); continuous psum_valid with acc_len=3 over 9 cycles -> 3 results, no gaps, ovr=0 with out_ready=1.
